// File: rtl/call_stack.sv
// call_stack: parametrised return-address stack with ring-buffer storage, replace-top, and sticky error flags.
// Define CALL_STACK_WRAP_EN so that a push while full overwrites the oldest entry instead of being dropped.
module call_stack #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           data_in,
  input  logic                       clear_err,
  output logic [WIDTH-1:0]           top,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty,
  output logic                       full,
  output logic                       overflow,
  output logic                       underflow
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wp_q, wp_d, top_idx, wr_addr;
  logic [CW-1:0]    count_q, count_d;
  logic             overflow_q, overflow_d, underflow_q, underflow_d;
  logic             do_replace, do_push, do_pop, wr_en;
  assign empty     = count_q == '0;
  assign full      = count_q == CW'(DEPTH);
  assign count     = count_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;
  assign top_idx   = wp_q - AW'(1);
  assign top       = empty ? '0 : mem_q[top_idx];
  always_comb begin
    do_replace  = push && pop && !empty;
    do_push     = push && !do_replace;
    do_pop      = pop && !push && !empty;
`ifdef CALL_STACK_WRAP_EN
    wr_en       = do_replace || do_push;
`else
    wr_en       = do_replace || (do_push && !full);
`endif
    wr_addr     = do_replace ? top_idx : wp_q;
    wp_d        = (wr_en && !do_replace) ? wp_q + AW'(1) : do_pop ? wp_q - AW'(1) : wp_q;
    count_d     = (do_push && !full) ? count_q + CW'(1) : do_pop ? count_q - CW'(1) : count_q;
    // an error in the same cycle as clear_err leaves its flag set
    overflow_d  = (do_push && full) || (overflow_q && !clear_err);
    underflow_d = (pop && !push && empty) || (underflow_q && !clear_err);
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      wp_q        <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wp_q        <= wp_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  always_ff @(posedge clk)
    if (wr_en && !reset) mem_q[wr_addr] <= data_in;
endmodule

// File: doc/call_stack.md
# call_stack

Parametrised hardware return-address stack for the Limb CPU core. It replaces the fixed 256-entry, 8-bit call stack: width and depth are configurable, and it adds a combinational top-of-stack view, simultaneous push+pop (replace top), saturating occupancy flags, and sticky overflow/underflow error flags. The control path drives `push` on `call` and `pop` on `ret`. The fetch unit takes the return PC from `top` in the same cycle as the `ret`.

## Interface
- `WIDTH`, default 8: entry width in bits (PC width).
- `DEPTH`, default 16: number of entries. Must be a power of two and ≥ 2.
- `clk`  in  1  rising-edge clock; the block uses one clock only.
- `reset`  in  1  asynchronous, active-high reset.
- `push`  in  1  write `data_in` as the new top entry this cycle.
- `pop`  in  1  discard the current top entry this cycle.
- `data_in`  in  WIDTH  value to push (return PC).
- `clear_err`  in  1  synchronous clear of `overflow` and `underflow`.
- `top`  out  WIDTH  current top entry, combinational; 0 when empty.
- `count`  out  $clog2(DEPTH+1)  number of valid entries, 0..DEPTH.
- `empty`  out  1  `count == 0`.
- `full`  out  1  `count == DEPTH`.
- `overflow`  out  1  sticky flag: a push was attempted while full.
- `underflow`  out  1  sticky flag: a pop was attempted while empty.

## Operation
- Storage is a ring buffer `mem[DEPTH]` with a write pointer `wp` ($clog2(DEPTH) bits, wraps modulo DEPTH) and a separate counter `count`.
- `top = empty ? 0 : mem[wp-1]`. The index is taken modulo DEPTH.
- Storage contents are not reset. Only pointers, count and flags are reset.
- Per-cycle actions, evaluated on `clk` edge:
  - Push only, not full: `mem[wp] <= data_in`; `wp++`; `count++`.
  - Push only, full: behaviour depends on the configuration macro (see Configuration). `overflow <= 1`.
  - Pop only, not empty: `wp--`; `count--`.
  - Pop only, empty: no state change. `underflow <= 1`.
  - Push+pop, not empty (this includes the full case): replace the top entry with `mem[wp-1] <= data_in`. `wp` and `count` are unchanged. No flag is set.
  - Push+pop, empty: behaves as push only. No `underflow` flag is set.
  - Neither push nor pop: hold.
- `clear_err` clears both sticky flags. If an error event occurs in the same cycle as `clear_err`, the error wins and its flag ends up set.
- `count` never exceeds DEPTH and never goes below 0.

## Timing
- Reset values: `wp = 0`, `count = 0`, `empty = 1`, `full = 0`, `overflow = 0`, `underflow = 0`, `top = 0`.
- Reset is asynchronous. Asserting `reset` mid-operation clears all state immediately. Any push or pop sampled while `reset` is high is discarded.
- Push latency is 1 cycle: `top`, `count` and the flags reflect the push after the next rising edge.
- Pop latency is 1 cycle: `top` shows the previous entry after the edge.
- `top` is valid combinationally in the cycle `pop` is asserted, so `ret` can consume it without a stall.
- `empty`, `full`, `overflow` and `underflow` are registered or derived from registered state only; they have no combinational path from `push` or `pop`.
- `top` depends only on registered state and storage; it has no combinational path from `data_in`.

## Configuration
- `CALL_STACK_WRAP_EN`:
  - Defined: a push while full writes `mem[wp]`, advances `wp` and leaves `count = DEPTH`. This overwrites the oldest entry, giving circular call-depth behaviour; `overflow` is still set.
  - Not defined: a push while full is dropped. `mem`, `wp` and `count` are unchanged, and `overflow` is set.

## Test plan
- Reset, then push 0x10, 0x20, 0x30 → `count = 3`, `top = 0x30`. Then pop ×3 → `top` reads 0x20, 0x10, then 0 with `empty = 1`.
- From empty, pop → `underflow = 1`, `count = 0`. Then `clear_err` → `underflow = 0` next cycle. Then pop and `clear_err` together → `underflow = 1`.
- Push 0x11, then push+pop with 0x22 → `count = 1`, `top = 0x22`. With stack empty, push+pop with 0x33 → `count = 1`, `top = 0x33`, `underflow = 0`.
- DEPTH=4: push 1, 2, 3, 4 (`full = 1`), then push 5 → `overflow = 1`.
  - Without the macro: `top = 4`; pops return 4, 3, 2, 1.
  - With `CALL_STACK_WRAP_EN`: `top = 5`; pops return 5, 4, 3, 2.
- WIDTH=12, DEPTH=8: push 0xABC ×8, then push+pop 0x123 while full → `count = 8`, `top = 0x123`, `overflow = 0`.
- Push 0x44 with `reset` asserted mid-cycle → all outputs return to reset values immediately, and the push is not recorded after `reset` is released.
